// File: rtl/dtpu_outfifo_stream.sv
// dtpu_outfifo_stream: output FIFO to AXI4-Stream master with length/flush TLAST; DTPU_OUTSTREAM_STATS_EN adds beat/packet/drop counters
module dtpu_outfifo_stream #(
    parameter int DATA_WIDTH_FIFO_OUT = 64,
    parameter int DEPTH = 16,
    parameter int PKT_LEN_W = 16
) (
    input  logic                           clk,
    input  logic                           aresetn,
`ifdef DTPU_OUTSTREAM_STATS_EN
    input  logic                           stat_clr,
    output logic [31:0]                    stat_beats,
    output logic [15:0]                    stat_pkts,
    output logic [15:0]                    stat_drops,
`endif
    input  logic [DATA_WIDTH_FIFO_OUT-1:0] outfifo_din,
    input  logic                           outfifo_write,
    output logic                           outfifo_is_full,
    input  logic                           flush,
    input  logic [PKT_LEN_W-1:0]           pkt_len,
    input  logic                           enable,
    output logic [DATA_WIDTH_FIFO_OUT-1:0] m_axis_tdata,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic                           m_axis_tlast,
    output logic                           overflow,
    output logic                           empty
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic {IDLE, OPEN} state_t;
    state_t state, state_nx;
    logic [DATA_WIDTH_FIFO_OUT:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic [PKT_LEN_W-1:0] wr_beat, len_q, len_eff;
    logic flush_pend, wr_acc, rd, tag;
    assign outfifo_is_full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign m_axis_tvalid = enable & ~empty;
    assign rd = m_axis_tvalid & m_axis_tready;
    assign wr_acc = outfifo_write & ~outfifo_is_full;
    // The first word of a packet is judged against the live pkt_len it is about to latch
    assign len_eff = state == IDLE ? pkt_len : len_q;
    assign tag = (len_eff != '0 && wr_beat == len_eff - 1'b1) | flush | flush_pend;
    assign m_axis_tdata = empty ? '0 : mem[rd_ptr][DATA_WIDTH_FIFO_OUT-1:0];
    assign m_axis_tlast = ~empty & mem[rd_ptr][DATA_WIDTH_FIFO_OUT];
    always_comb begin
        state_nx = state;
        if (wr_acc)
            state_nx = tag ? IDLE : OPEN;
    end
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
            wr_beat <= '0;
            len_q <= '0;
            flush_pend <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_nx;
            if (wr_acc) begin
                wr_beat <= tag ? '0 : wr_beat + 1'b1;
                flush_pend <= 1'b0;
                if (state == IDLE)
                    len_q <= pkt_len;
            end else if (flush && state == OPEN) begin
                flush_pend <= 1'b1;
            end
            if (wr_acc)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(wr_acc) - (AW+1)'(rd);
            if (outfifo_write && outfifo_is_full)
                overflow <= 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wr_ptr] <= {tag, outfifo_din};
    end
`ifdef DTPU_OUTSTREAM_STATS_EN
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            stat_beats <= '0;
            stat_pkts <= '0;
            stat_drops <= '0;
        end else if (stat_clr) begin
            stat_beats <= '0;
            stat_pkts <= '0;
            stat_drops <= '0;
        end else begin
            if (rd && stat_beats != '1)
                stat_beats <= stat_beats + 1'b1;
            if (rd && m_axis_tlast && stat_pkts != '1)
                stat_pkts <= stat_pkts + 1'b1;
            if (outfifo_write && outfifo_is_full && stat_drops != '1)
                stat_drops <= stat_drops + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_dtpu_outfifo_stream.sv
// tb_dtpu_outfifo_stream: table vectors, directed corner sequences and random traffic against a queue model
module tb_dtpu_outfifo_stream;
    logic clk = 1'b0, aresetn = 1'b0;
    logic [63:0] din = '0;
    logic wr = 1'b0, flush = 1'b0, enable = 1'b1, ready = 1'b0, stat_clr = 1'b0;
    logic [15:0] pkt_len = '0;
    logic [63:0] tdata;
    logic tvalid, tlast, full, overflow, empty;
`ifdef DTPU_OUTSTREAM_STATS_EN
    logic [31:0] stat_beats;
    logic [15:0] stat_pkts, stat_drops;
`endif
    always #5 clk = ~clk;
    dtpu_outfifo_stream dut (
        .clk(clk), .aresetn(aresetn),
`ifdef DTPU_OUTSTREAM_STATS_EN
        .stat_clr(stat_clr), .stat_beats(stat_beats), .stat_pkts(stat_pkts), .stat_drops(stat_drops),
`endif
        .outfifo_din(din), .outfifo_write(wr), .outfifo_is_full(full), .flush(flush),
        .pkt_len(pkt_len), .enable(enable), .m_axis_tdata(tdata), .m_axis_tvalid(tvalid),
        .m_axis_tready(ready), .m_axis_tlast(tlast), .overflow(overflow), .empty(empty)
    );
    typedef struct {logic [63:0] d; logic l;} ent_t;
    typedef struct {logic w; logic [63:0] d; logic f; logic r; logic [15:0] plen; logic ev; logic el;} vec_t;
    ent_t q[$];
    bit m_open, m_pend, m_ovf;
    int m_pos, m_len;
    longint m_beats, m_pkts, m_drops;
    int checks = 0, errors = 0;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic model_clear();
        q.delete();
        m_open = 0; m_pend = 0; m_ovf = 0; m_pos = 0; m_len = 0;
        m_beats = 0; m_pkts = 0; m_drops = 0;
    endtask
    task automatic do_reset();
        aresetn = 1'b0;
        #1;
        chk("rst_tvalid", 64'(tvalid), 0);
        chk("rst_empty", 64'(empty), 1);
        chk("rst_tdata", tdata, 0);
        chk("rst_tlast", 64'(tlast), 0);
        chk("rst_full", 64'(full), 0);
        chk("rst_overflow", 64'(overflow), 0);
        model_clear();
        @(negedge clk);
        aresetn = 1'b1;
    endtask
    task automatic drive(input logic w, input logic [63:0] d, input logic f, input logic r);
        wr = w; din = d; flush = f; ready = r;
        #1;
    endtask
    task automatic check_model();
        chk("tvalid", 64'(tvalid), 64'(enable && q.size() > 0));
        chk("empty", 64'(empty), 64'(q.size() == 0));
        chk("full", 64'(full), 64'(q.size() == 16));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        if (q.size() > 0) begin
            chk("tdata", tdata, q[0].d);
            chk("tlast", 64'(tlast), 64'(q[0].l));
        end
`ifdef DTPU_OUTSTREAM_STATS_EN
        chk("stat_beats", 64'(stat_beats), 64'(m_beats));
        chk("stat_pkts", 64'(stat_pkts), 64'(m_pkts));
        chk("stat_drops", 64'(stat_drops), 64'(m_drops));
`endif
    endtask
    task automatic tick();
        bit rdv, acc, tag;
        int leff;
        rdv = enable && q.size() > 0 && ready;
        acc = wr && q.size() < 16;
        if (wr && !acc) m_ovf = 1;
        if (stat_clr) begin
            m_beats = 0; m_pkts = 0; m_drops = 0;
        end else begin
            if (rdv && m_beats < 64'hFFFF_FFFF) m_beats++;
            if (rdv && q[0].l && m_pkts < 65535) m_pkts++;
            if (wr && !acc && m_drops < 65535) m_drops++;
        end
        tag = 0;
        if (acc) begin
            leff = m_open ? m_len : int'(pkt_len);
            tag = (leff != 0 && m_pos + 1 == leff) || flush || m_pend;
            if (tag) begin
                m_open = 0; m_pos = 0; m_pend = 0;
            end else begin
                if (!m_open) m_len = int'(pkt_len);
                m_open = 1; m_pos++;
            end
        end else if (flush && m_open) begin
            m_pend = 1;
        end
        if (rdv) void'(q.pop_front());
        if (acc) q.push_back('{d: din, l: tag});
        @(posedge clk);
        @(negedge clk);
    endtask
    task automatic step(input logic w, input logic [63:0] d, input logic f, input logic r);
        drive(w, d, f, r);
        check_model();
        tick();
    endtask
    vec_t tbl[16];
    int n;
    initial begin
        tbl[0]  = '{1, 64'h1111111111111111, 0, 1, 4, 0, 0};
        tbl[1]  = '{1, 64'h2222222222222222, 0, 1, 4, 1, 0};
        tbl[2]  = '{1, 64'h3333333333333333, 0, 1, 4, 1, 0};
        tbl[3]  = '{1, 64'h4444444444444444, 0, 1, 4, 1, 0};
        tbl[4]  = '{0, 64'h0, 0, 1, 4, 1, 1};
        tbl[5]  = '{0, 64'h0, 0, 1, 0, 0, 0};
        tbl[6]  = '{1, 64'h5555555555555555, 0, 1, 0, 0, 0};
        tbl[7]  = '{1, 64'h6666666666666666, 0, 1, 0, 1, 0};
        tbl[8]  = '{1, 64'h7777777777777777, 0, 1, 0, 1, 0};
        tbl[9]  = '{0, 64'h0, 1, 1, 0, 1, 0};
        tbl[10] = '{1, 64'h8888888888888888, 0, 1, 0, 0, 0};
        tbl[11] = '{0, 64'h0, 0, 1, 0, 1, 1};
        tbl[12] = '{0, 64'h0, 1, 1, 0, 0, 0};
        tbl[13] = '{1, 64'h9999999999999999, 0, 1, 0, 0, 0};
        tbl[14] = '{0, 64'h0, 0, 1, 0, 1, 0};
        tbl[15] = '{0, 64'h0, 0, 1, 0, 0, 0};
        model_clear();
        @(negedge clk);
        do_reset();
        foreach (tbl[i]) begin
            pkt_len = tbl[i].plen;
            drive(tbl[i].w, tbl[i].d, tbl[i].f, tbl[i].r);
            chk($sformatf("vec%0d_tvalid", i), 64'(tvalid), 64'(tbl[i].ev));
            chk($sformatf("vec%0d_tlast", i), 64'(tlast), 64'(tbl[i].el));
            check_model();
            tick();
        end
        // fill past full, then drain
        do_reset();
        pkt_len = 0;
        for (int i = 0; i < 17; i++) step(1, 64'(i + 100), 0, 0);
        drive(0, 0, 0, 0);
        chk("fill_full", 64'(full), 1);
        chk("fill_overflow", 64'(overflow), 1);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 0, 1);
            if (tvalid) n++;
            check_model();
            tick();
        end
        chk("drain_beats", 64'(n), 16);
        chk("drain_empty", 64'(empty), 1);
        // stall holds head, then steady-state pass-through at count 3
        do_reset();
        step(1, 64'hAAAAAAAAAAAAAAAA, 0, 0);
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0);
            chk("stall_tdata", tdata, 64'hAAAAAAAAAAAAAAAA);
            chk("stall_tlast", 64'(tlast), 0);
            tick();
        end
        step(1, 64'hB0, 0, 0);
        step(1, 64'hB1, 0, 0);
        for (int i = 0; i < 10; i++) step(1, 64'(i + 64'hC0), 0, 1);
        drive(0, 0, 0, 0);
        chk("steady_count", 64'(q.size()), 3);
        check_model();
        // async reset mid-packet, then a fresh 2-beat packet
        pkt_len = 3;
        for (int i = 0; i < 2; i++) step(1, 64'(i + 64'hD0), 0, 0);
        drive(0, 0, 0, 0);
        chk("pre_rst_tvalid", 64'(tvalid), 1);
        do_reset();
        pkt_len = 2;
        step(1, 64'hE0, 0, 0);
        step(1, 64'hE1, 0, 0);
        drive(0, 0, 0, 1);
        chk("pkt2_first_tlast", 64'(tlast), 0);
        tick();
        drive(0, 0, 0, 1);
        chk("pkt2_second_tdata", tdata, 64'hE1);
        chk("pkt2_second_tlast", 64'(tlast), 1);
        tick();
`ifdef DTPU_OUTSTREAM_STATS_EN
        do_reset();
        pkt_len = 3;
        for (int i = 0; i < 6; i++) step(1, 64'(i), 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
        for (int i = 0; i < 17; i++) step(1, 64'(i), 0, 0);
        drive(0, 0, 0, 0);
        chk("st_beats", 64'(stat_beats), 6);
        chk("st_pkts", 64'(stat_pkts), 2);
        chk("st_drops", 64'(stat_drops), 1);
        stat_clr = 1;
        step(1, 0, 0, 1);
        stat_clr = 0;
        drive(0, 0, 0, 0);
        chk("st_clr_beats", 64'(stat_beats), 0);
        chk("st_clr_pkts", 64'(stat_pkts), 0);
        chk("st_clr_drops", 64'(stat_drops), 0);
`endif
        // random traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) pkt_len = 16'($urandom_range(0, 5));
            enable = $urandom_range(0, 9) != 0;
            stat_clr = $urandom_range(0, 39) == 0;
            step($urandom_range(0, 2) != 0, {$urandom, $urandom}, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 3) < (i < 300 ? 1 : 3));
        end
        stat_clr = 0;
        enable = 1;
        for (int i = 0; i < 20; i++) step(0, 0, 0, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
